// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the 5-stage integer pipe.
// Load-use stalls are held for LOAD_LAT cycles; stall events are counted.
module hazard_forward_unit #(
  parameter int RA_W         = 5,
  parameter int LOAD_LAT     = 1,
  parameter bit STORE_FWD_EN = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_memwrite,
  input  logic [RA_W-1:0] ex_rs,
  input  logic [RA_W-1:0] ex_rt,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic            ex_memwrite,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_regwrite,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            fwd_store,
  output logic            stall,
  output logic            bubble,
  output logic [CNT_W-1:0] stall_events
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] EV_MAX = '1;

  state_t     state;
  logic [3:0] cnt;

  logic mem_ok;
  logic wb_ok;
  logic mem_a;
  logic mem_b;
  logic wb_a;
  logic wb_b;

  assign mem_ok = mem_regwrite && (mem_rd != '0);
  assign wb_ok  = wb_regwrite && (wb_rd != '0);
  assign mem_a  = mem_ok && (mem_rd == ex_rs);
  assign mem_b  = mem_ok && (mem_rd == ex_rt);
  assign wb_a   = wb_ok && (wb_rd == ex_rs);
  assign wb_b   = wb_ok && (wb_rd == ex_rt);

  // The younger EX/MEM result wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    priority case (1'b1)
      mem_a:   fwd_a = 2'b10;
      wb_a:    fwd_a = 2'b01;
      default: fwd_a = 2'b00;
    endcase
  end

  always_comb begin
    fwd_b = 2'b00;
    priority case (1'b1)
      mem_b:   fwd_b = 2'b10;
      wb_b:    fwd_b = 2'b01;
      default: fwd_b = 2'b00;
    endcase
  end

  assign fwd_store = STORE_FWD_EN && ex_memwrite
                  && mem_memread && mem_b;

  logic rs_hit;
  logic rt_hit;
  logic exempt;
  logic load_use;

  assign rs_hit = (ex_rd == id_rs);
  assign rt_hit = (ex_rd == id_rt);

  // Store data alone can be picked up later by fwd_store.
  assign exempt = STORE_FWD_EN && id_memwrite
               && rt_hit && !rs_hit;

  assign load_use = id_valid && ex_memread && ex_regwrite
                 && (ex_rd != '0) && (rs_hit || rt_hit)
                 && !exempt;

  logic new_event;

  assign new_event = (state == IDLE) && load_use;
  assign stall     = new_event || (state == HOLD);
  assign bubble    = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_use && (LOAD_LAT > 1)) begin
            state <= HOLD;
            cnt   <= CNT_INIT;
          end
        end
        HOLD: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_events <= '0;
    end else if (new_event && (stall_events != EV_MAX)) begin
      stall_events <= stall_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: three parameterisations share one stimulus.
// A: LAT3/store-fwd/16b, B: LAT4/no-store-fwd/2b, C: defaults.
module tb_hazard_forward_unit;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_memwrite;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_memread;
    logic       ex_memwrite;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic       mem_memread;
    logic [4:0] wb_rd;
    logic       wb_regwrite;
  } in_t;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [2:0]  fs;
    logic [2:0]  st;
    logic [15:0] ea;
    logic [1:0]  eb;
    logic [15:0] ec;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  typedef struct {
    string name;
    exp_t  e;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       id_valid;
  logic [4:0] id_rs, id_rt;
  logic       id_memwrite;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic       ex_regwrite, ex_memread, ex_memwrite;
  logic [4:0] mem_rd;
  logic       mem_regwrite, mem_memread;
  logic [4:0] wb_rd;
  logic       wb_regwrite;

  logic [1:0]  fwd_a [3];
  logic [1:0]  fwd_b [3];
  logic        fwd_st [3];
  logic        stall [3];
  logic        bubble [3];
  logic [15:0] ev_a;
  logic [1:0]  ev_b;
  logic [15:0] ev_c;

  int n_vec = 0;
  int n_err = 0;
  sb_t  sb [$];
  vec_t tbl [$];

  always #5 clk = ~clk;

  hazard_forward_unit #(
    .RA_W(5), .LOAD_LAT(3), .STORE_FWD_EN(1'b1), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_memwrite(id_memwrite),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .fwd_store(fwd_st[0]),
    .stall(stall[0]), .bubble(bubble[0]), .stall_events(ev_a)
  );

  hazard_forward_unit #(
    .RA_W(5), .LOAD_LAT(4), .STORE_FWD_EN(1'b0), .CNT_W(2)
  ) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_memwrite(id_memwrite),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .fwd_store(fwd_st[1]),
    .stall(stall[1]), .bubble(bubble[1]), .stall_events(ev_b)
  );

  hazard_forward_unit u_c (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_memwrite(id_memwrite),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .fwd_store(fwd_st[2]),
    .stall(stall[2]), .bubble(bubble[2]), .stall_events(ev_c)
  );

  function automatic exp_t mk(logic [1:0] fa, logic [1:0] fb,
                              logic [2:0] fs, logic [2:0] st,
                              int ea, int eb, int ec);
    exp_t r;
    r.fa = fa;
    r.fb = fb;
    r.fs = fs;
    r.st = st;
    r.ea = 16'(ea);
    r.eb = 2'(eb);
    r.ec = 16'(ec);
    return r;
  endfunction

  function automatic in_t fw(logic [4:0] rs, logic [4:0] rt,
                             logic [4:0] mrd, logic mrw, logic mmr,
                             logic [4:0] wrd, logic wrw, logic emw);
    in_t r;
    r = '0;
    r.ex_rs = rs;
    r.ex_rt = rt;
    r.mem_rd = mrd;
    r.mem_regwrite = mrw;
    r.mem_memread = mmr;
    r.wb_rd = wrd;
    r.wb_regwrite = wrw;
    r.ex_memwrite = emw;
    return r;
  endfunction

  function automatic in_t ld(logic [4:0] rs, logic [4:0] rt,
                             logic [4:0] rd, logic mw);
    in_t r;
    r = '0;
    r.id_valid = 1'b1;
    r.id_rs = rs;
    r.id_rt = rt;
    r.id_memwrite = mw;
    r.ex_rd = rd;
    r.ex_memread = 1'b1;
    r.ex_regwrite = 1'b1;
    return r;
  endfunction

  task automatic add(string n, in_t i, exp_t e);
    vec_t v;
    v.name = n;
    v.i = i;
    v.e = e;
    tbl.push_back(v);
  endtask

  task automatic apply(in_t v);
    id_valid = v.id_valid;
    id_rs = v.id_rs;
    id_rt = v.id_rt;
    id_memwrite = v.id_memwrite;
    ex_rs = v.ex_rs;
    ex_rt = v.ex_rt;
    ex_rd = v.ex_rd;
    ex_regwrite = v.ex_regwrite;
    ex_memread = v.ex_memread;
    ex_memwrite = v.ex_memwrite;
    mem_rd = v.mem_rd;
    mem_regwrite = v.mem_regwrite;
    mem_memread = v.mem_memread;
    wb_rd = v.wb_rd;
    wb_regwrite = v.wb_regwrite;
  endtask

  task automatic cmp(string n, string f,
                     logic [15:0] act, logic [15:0] want);
    if (act !== want) begin
      n_err++;
      $display("FAIL %s %s: got %0h want %0h", n, f, act, want);
    end
  endtask

  task automatic push(string n, exp_t e);
    sb_t s;
    s.name = n;
    s.e = e;
    sb.push_back(s);
  endtask

  task automatic check();
    sb_t s;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: got empty want entry");
      return;
    end
    s = sb.pop_front();
    n_vec++;
    for (int k = 0; k < 3; k++) begin
      cmp(s.name, $sformatf("fwd_a[%0d]", k),
          16'(fwd_a[k]), 16'(s.e.fa));
      cmp(s.name, $sformatf("fwd_b[%0d]", k),
          16'(fwd_b[k]), 16'(s.e.fb));
      cmp(s.name, $sformatf("fwd_store[%0d]", k),
          16'(fwd_st[k]), 16'(s.e.fs[2-k]));
      cmp(s.name, $sformatf("stall[%0d]", k),
          16'(stall[k]), 16'(s.e.st[2-k]));
      cmp(s.name, $sformatf("bubble[%0d]", k),
          16'(bubble[k]), 16'(s.e.st[2-k]));
    end
    cmp(s.name, "events_a", ev_a, s.e.ea);
    cmp(s.name, "events_b", 16'(ev_b), 16'(s.e.eb));
    cmp(s.name, "events_c", ev_c, s.e.ec);
  endtask

  task automatic step(string n, in_t v, exp_t e, logic r);
    @(posedge clk);
    #1;
    rst = r;
    apply(v);
    push(n, e);
    @(negedge clk);
    check();
  endtask

  initial begin
    in_t z;
    in_t v;
    int ea, eb, ec;
    z = '0;

    add("prio_mem", fw(3, 0, 3, 1, 0, 3, 1, 0),
        mk(2'b10, 2'b00, 3'b000, 3'b000, 0, 0, 0));
    add("prio_wb", fw(3, 0, 3, 0, 0, 3, 1, 0),
        mk(2'b01, 2'b00, 3'b000, 3'b000, 0, 0, 0));
    add("zero_rd", fw(0, 0, 0, 1, 0, 0, 1, 0),
        mk(2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0));
    add("b_mem_a_wb", fw(9, 4, 4, 1, 0, 9, 1, 0),
        mk(2'b01, 2'b10, 3'b000, 3'b000, 0, 0, 0));
    add("both_wb", fw(12, 12, 12, 0, 0, 12, 1, 0),
        mk(2'b01, 2'b01, 3'b000, 3'b000, 0, 0, 0));
    add("both_mem", fw(31, 31, 31, 1, 0, 31, 1, 0),
        mk(2'b10, 2'b10, 3'b000, 3'b000, 0, 0, 0));
    add("wb_rd0", fw(0, 5, 5, 1, 0, 0, 1, 0),
        mk(2'b00, 2'b10, 3'b000, 3'b000, 0, 0, 0));
    add("st_fwd", fw(0, 7, 7, 1, 1, 0, 0, 1),
        mk(2'b00, 2'b10, 3'b101, 3'b000, 0, 0, 0));
    add("st_no_mr", fw(0, 7, 7, 1, 0, 0, 0, 1),
        mk(2'b00, 2'b10, 3'b000, 3'b000, 0, 0, 0));
    add("st_no_mw", fw(0, 7, 7, 1, 1, 0, 0, 0),
        mk(2'b00, 2'b10, 3'b000, 3'b000, 0, 0, 0));
    add("st_no_rw", fw(0, 7, 7, 0, 1, 0, 0, 1),
        mk(2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0));
    add("st_rd0", fw(0, 0, 0, 1, 1, 0, 0, 1),
        mk(2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0));
    add("st_rt_miss", fw(0, 6, 7, 1, 1, 0, 0, 1),
        mk(2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0));
    v = ld(5, 0, 5, 0);
    v.id_valid = 1'b0;
    add("lu_no_valid", v,
        mk(2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0));
    add("lu_rd0", ld(0, 0, 0, 0),
        mk(2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0));
    v = ld(5, 0, 5, 0);
    v.ex_memread = 1'b0;
    add("lu_no_mr", v,
        mk(2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0));
    v = ld(5, 0, 5, 0);
    v.ex_regwrite = 1'b0;
    add("lu_no_rw", v,
        mk(2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0));
    add("lu_nomatch", ld(4, 6, 5, 0),
        mk(2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0));

    // reset state
    rst = 1'b1;
    apply(z);
    #2;
    push("reset", mk(2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0));
    check();

    foreach (tbl[n]) step(tbl[n].name, tbl[n].i, tbl[n].e, 1'b0);

    // load-use on rs, held for A's three cycles
    step("lu0", ld(5, 0, 5, 0), mk(0, 0, 0, 3'b111, 0, 0, 0), 0);
    step("lu1", ld(5, 0, 5, 0), mk(0, 0, 0, 3'b111, 1, 1, 1), 0);
    step("lu2", ld(5, 0, 5, 0), mk(0, 0, 0, 3'b111, 1, 1, 2), 0);
    step("lu3", z, mk(0, 0, 0, 3'b010, 1, 1, 3), 0);
    step("lu4", z, mk(0, 0, 0, 3'b000, 1, 1, 3), 0);

    // load then store: exempt unless store forwarding is off
    step("ls0", ld(2, 7, 7, 1), mk(0, 0, 0, 3'b010, 1, 1, 3), 0);
    step("ls1", fw(0, 7, 7, 1, 1, 0, 0, 1),
         mk(2'b00, 2'b10, 3'b101, 3'b010, 1, 2, 3), 0);
    step("ls2", z, mk(0, 0, 0, 3'b010, 1, 2, 3), 0);
    step("ls3", z, mk(0, 0, 0, 3'b010, 1, 2, 3), 0);
    step("ls4", z, mk(0, 0, 0, 3'b000, 1, 2, 3), 0);

    // store with rs also matching is a real hazard, then reset mid-hold
    step("rh0", ld(6, 6, 6, 1), mk(0, 0, 0, 3'b111, 1, 2, 3), 0);
    step("rh1", z, mk(0, 0, 0, 3'b110, 2, 3, 4), 0);
    #2;
    rst = 1'b1;
    #1;
    push("rst_async", mk(0, 0, 0, 3'b000, 0, 0, 0));
    check();
    step("rst_lu", ld(5, 0, 5, 0), mk(0, 0, 0, 3'b111, 0, 0, 0), 1);
    step("rst_rel", z, mk(0, 0, 0, 3'b000, 0, 0, 0), 0);
    step("rr0", ld(5, 0, 5, 0), mk(0, 0, 0, 3'b111, 0, 0, 0), 0);
    step("rr1", z, mk(0, 0, 0, 3'b110, 1, 1, 1), 0);
    step("rr2", z, mk(0, 0, 0, 3'b110, 1, 1, 1), 0);
    step("rr3", z, mk(0, 0, 0, 3'b010, 1, 1, 1), 0);
    step("rr4", z, mk(0, 0, 0, 3'b000, 1, 1, 1), 0);

    // separated hazards drive B's 2-bit counter into saturation
    ea = 1;
    eb = 1;
    ec = 1;
    for (int h = 0; h < 5; h++) begin
      v = (h % 2 == 0) ? ld(5, 0, 5, 0) : ld(0, 5, 5, 0);
      step("sat0", v, mk(0, 0, 0, 3'b111, ea, eb, ec), 0);
      ea++;
      ec++;
      if (eb < 3) eb++;
      step("sat1", z, mk(0, 0, 0, 3'b110, ea, eb, ec), 0);
      step("sat2", z, mk(0, 0, 0, 3'b110, ea, eb, ec), 0);
      step("sat3", z, mk(0, 0, 0, 3'b010, ea, eb, ec), 0);
      step("sat4", z, mk(0, 0, 0, 3'b000, ea, eb, ec), 0);
    end

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter RA_W, default 5, SHALL set the register-address width.
REQ-002 Parameter LOAD_LAT, default 1, range 1..15, SHALL set the load-use stall length in cycles.
REQ-003 Parameter STORE_FWD_EN, default 1, SHALL enable the load-to-store data-forward path and its stall exemption.
REQ-004 Parameter CNT_W, default 16, SHALL set the stall-event counter width.
REQ-005 Ports SHALL be as follows: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  decode-stage instruction valid
- id_rs, id_rt  in  RA_W  decode-stage source registers
- id_memwrite  in  1  decode-stage instruction is a store
- ex_rs, ex_rt, ex_rd  in  RA_W  execute-stage source and destination registers
- ex_regwrite, ex_memread, ex_memwrite  in  1  execute-stage control
- mem_rd  in  RA_W  memory-stage destination register
- mem_regwrite, mem_memread  in  1  memory-stage control
- wb_rd  in  RA_W  writeback-stage destination register
- wb_regwrite  in  1  writeback-stage control
- fwd_a, fwd_b  out  2  ALU operand select: 00 register file, 10 EX/MEM, 01 MEM/WB
- fwd_store  out  1  store-data select: 1 selects the MEM-stage load result
- stall  out  1  freeze PC and IF/ID
- bubble  out  1  zero ID/EX control
- stall_events  out  CNT_W  load-use events detected since reset

Function
REQ-006 fwd_a SHALL be 10 when mem_regwrite, mem_rd!=0 and mem_rd==ex_rs; otherwise 01 when wb_regwrite, wb_rd!=0 and wb_rd==ex_rs; otherwise 00.
REQ-007 fwd_b SHALL apply the same priority as REQ-006 against ex_rt.
REQ-008 fwd_a, fwd_b and fwd_store SHALL be combinational, with no latency.
REQ-009 fwd_store SHALL be 1 only when STORE_FWD_EN=1, ex_memwrite, mem_memread, mem_regwrite, mem_rd!=0 and mem_rd==ex_rt.
REQ-010 load_use SHALL be true when all of the following hold:
- id_valid, ex_memread and ex_regwrite are asserted;
- ex_rd!=0;
- ex_rd==id_rs, or ex_rd==id_rt;
- the exemption below does not apply.
REQ-011 Exemption: with STORE_FWD_EN=1 and id_memwrite, a match on id_rt alone (ex_rd!=id_rs) SHALL NOT be a load-use hazard.
REQ-012 The FSM SHALL have two states, IDLE and HOLD, with a down-counter cnt of 4 bits.
REQ-013 In IDLE with load_use true:
- if LOAD_LAT>1, the FSM SHALL go to HOLD next cycle with cnt=LOAD_LAT-1;
- if LOAD_LAT=1, it SHALL remain in IDLE.
REQ-014 In HOLD, cnt SHALL decrement every cycle, and the FSM SHALL return to IDLE on the edge where cnt==1.
REQ-015 stall and bubble SHALL equal (IDLE and load_use) or HOLD, so each hazard yields exactly LOAD_LAT stall cycles.
REQ-016 In HOLD, load_use SHALL be ignored; no event SHALL be counted and the count SHALL NOT restart.
REQ-017 stall_events SHALL increment by 1 on each IDLE-cycle load_use.
REQ-018 stall_events SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-019 A destination of 0 SHALL never produce forwarding, fwd_store or a stall.
REQ-020 Simultaneous EX/MEM and MEM/WB matches SHALL select EX/MEM (10).

Reset
REQ-021 rst asserted SHALL immediately force:
- state=IDLE and cnt=0;
- stall_events=0;
- stall=0 and bubble=0, unless load_use is true combinationally.
REQ-022 rst asserted during HOLD SHALL abort the stall, and the FSM SHALL resume in IDLE after deassertion.

Verification
REQ-023 Forward priority: mem_rd=wb_rd=ex_rs=3, both regwrite=1 -> fwd_a=10; with mem_regwrite=0 -> fwd_a=01; with ex_rs=0 and rds=0 -> fwd_a=00.
REQ-024 Load-use, LOAD_LAT=3: ex_memread=1, ex_rd=5, id_rs=5 held -> stall=bubble=1 for exactly 3 cycles, stall_events=1.
REQ-025 Load-then-store: id_memwrite=1, id_rt=ex_rd=7, id_rs=2 -> stall=0; next cycle with mem_memread=1, mem_rd=7, ex_memwrite=1, ex_rt=7 -> fwd_store=1.
REQ-026 Same as REQ-025 with STORE_FWD_EN=0 -> stall for LOAD_LAT cycles and fwd_store=0.
REQ-027 Reset mid-HOLD: rst pulsed in the 2nd stall cycle of LOAD_LAT=4 -> stall drops asynchronously, stall_events=0, next hazard gives a full 4-cycle stall.
REQ-028 Saturation: CNT_W=2, 5 separated hazards -> stall_events reads 3.
